// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multi-cycle datapath with timed memory handshakes
module multicycle_control #(
  parameter int OPW = 6,
  parameter int FUNCTW = 6,
  parameter int TIMEOUT = 15,
  parameter logic [FUNCTW-1:0] FUNCT_BRV = 6'b010100,
  parameter logic [FUNCTW-1:0] FUNCT_JMX = 6'b010101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic [FUNCTW-1:0] funct,
  input  logic              mem_ready,
  output logic              pcwrite,
  output logic              pcwritecond,
  output logic [1:0]        brcond,
  output logic [1:0]        iord,
  output logic              memread,
  output logic              memwrite,
  output logic              irwrite,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic              regwrite,
  output logic [1:0]        alusrca,
  output logic [1:0]        alusrcb,
  output logic [1:0]        aluop,
  output logic [1:0]        pcsource,
  output logic [4:0]        state,
  output logic              illegal,
  output logic              mem_err
);
  localparam logic [OPW-1:0] OP_R      = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW     = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW     = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ    = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_NANDI  = OPW'(6'b011100);
  localparam logic [OPW-1:0] OP_BLEZAL = OPW'(6'b100100);
  localparam logic [OPW-1:0] OP_BALV   = OPW'(6'b011110);
  localparam logic [OPW-1:0] OP_JALPC  = OPW'(6'b011111);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ,
    IEX, IWB, BLEZAL, BALV, JALPC, BRV, JMX_RD, JMX_JMP
  } state_t;
  state_t st, nx;
  logic [CW-1:0] cnt;
  logic wait_st, to;
  assign wait_st = st inside {FETCH, MEMRD, MEMWR, JMX_RD};
  assign to = (TIMEOUT != 0) && rst_n && wait_st && !mem_ready && cnt == TLIM;
  assign state = rst_n ? st : 5'd0;
  // state register and wait counter; counter clears whenever a wait state is (re)entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= nx;
      cnt <= (nx == st && !to) ? cnt + 1'b1 : '0;
    end
  end
  // next state and Moore outputs; only FETCH's irwrite/pcwrite follow mem_ready
  always_comb begin
    nx = FETCH;
    pcwrite = 1'b0; pcwritecond = 1'b0; brcond = 2'b00; iord = 2'b00;
    memread = 1'b0; memwrite = 1'b0; irwrite = 1'b0; regdst = 2'b00;
    memtoreg = 2'b00; regwrite = 1'b0; alusrca = 2'b00; alusrcb = 2'b00;
    aluop = 2'b00; pcsource = 2'b00; illegal = 1'b0;
    mem_err = to;
    if (rst_n) begin
      case (st)
        FETCH: begin
          memread = 1'b1; alusrcb = 2'b01;
          irwrite = mem_ready; pcwrite = mem_ready;
          nx = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alusrcb = 2'b11;
          case (opcode)
            OP_LW, OP_SW: nx = MEMADR;
            OP_BEQ:       nx = BEQ;
            OP_NANDI:     nx = IEX;
            OP_BLEZAL:    nx = BLEZAL;
            OP_BALV:      nx = BALV;
            OP_JALPC:     nx = JALPC;
            OP_R:         nx = funct == FUNCT_BRV ? BRV : funct == FUNCT_JMX ? JMX_RD : REX;
            default:      illegal = 1'b1;
          endcase
        end
        MEMADR: begin
          alusrca = 2'b01; alusrcb = 2'b10;
          nx = opcode == OP_SW ? MEMWR : MEMRD;
        end
        MEMRD: begin
          memread = 1'b1; iord = 2'b01;
          nx = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          regwrite = 1'b1; memtoreg = 2'b01;
        end
        MEMWR: begin
          memwrite = 1'b1; iord = 2'b01;
          nx = mem_ready ? FETCH : MEMWR;
        end
        REX: begin
          alusrca = 2'b01; aluop = 2'b10; nx = RWB;
        end
        RWB: begin
          regwrite = 1'b1; regdst = 2'b01;
        end
        BEQ: begin
          alusrca = 2'b01; aluop = 2'b01; pcwritecond = 1'b1; pcsource = 2'b01;
        end
        IEX: begin
          alusrca = 2'b01; alusrcb = 2'b10; aluop = 2'b11; nx = IWB;
        end
        IWB: regwrite = 1'b1;
        BLEZAL: begin
          pcwritecond = 1'b1; brcond = 2'b01; pcsource = 2'b01;
          regwrite = 1'b1; regdst = 2'b10; memtoreg = 2'b10;
        end
        BALV: begin
          pcwritecond = 1'b1; brcond = 2'b10; pcsource = 2'b01;
          regwrite = 1'b1; regdst = 2'b10; memtoreg = 2'b10;
        end
        JALPC: begin
          pcwrite = 1'b1; pcsource = 2'b10;
          regwrite = 1'b1; regdst = 2'b10; memtoreg = 2'b10;
        end
        BRV: begin
          pcwritecond = 1'b1; brcond = 2'b10; pcsource = 2'b11;
        end
        JMX_RD: begin
          memread = 1'b1; iord = 2'b10;
          nx = mem_ready ? JMX_JMP : JMX_RD;
        end
        JMX_JMP: begin
          alusrca = 2'b10; aluop = 2'b11; pcwrite = 1'b1;
        end
        default: nx = FETCH;
      endcase
      if (to) nx = FETCH;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector check of the multi-cycle control FSM
module tb_multicycle_control;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_NANDI = 6'b011100, OP_BLEZAL = 6'b100100, OP_JALPC = 6'b011111;
  localparam logic [5:0] F_BRV = 6'b010100, F_JMX = 6'b010101;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
    S_MEMWR = 5, S_BEQ = 8, S_IEX = 9, S_IWB = 10, S_BLEZAL = 11, S_JALPC = 13,
    S_BRV = 14, S_JMX_RD = 15, S_JMX_JMP = 16;
  logic clk = 1'b0, rst_n, mem_ready;
  logic [5:0] opcode, funct;
  logic pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite, illegal, mem_err;
  logic [1:0] brcond, iord, regdst, memtoreg, alusrca, alusrcb, aluop, pcsource;
  logic [4:0] state;
  int checks = 0, failures = 0;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .brcond(brcond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource), .state(state), .illegal(illegal), .mem_err(mem_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; opcode = OP_R; funct = 6'd0; mem_ready = 1'b1;
    tick; tick;
    chk("rst_state", state, 0); chk("rst_memread", memread, 0); chk("rst_irwrite", irwrite, 0);
    rst_n = 1'b1; opcode = OP_LW; #1;
    chk("fetch_state", state, S_FETCH); chk("fetch_memread", memread, 1);
    chk("fetch_irwrite", irwrite, 1); chk("fetch_pcwrite", pcwrite, 1); chk("fetch_alusrcb", alusrcb, 1);
    tick; chk("lw_decode", state, S_DECODE); chk("decode_alusrcb", alusrcb, 3);
    tick; chk("lw_memadr", state, S_MEMADR); chk("memadr_alusrca", alusrca, 1); chk("memadr_alusrcb", alusrcb, 2);
    tick; chk("lw_memrd", state, S_MEMRD); chk("memrd_memread", memread, 1); chk("memrd_iord", iord, 1);
    tick; chk("lw_memwb", state, S_MEMWB); chk("memwb_regwrite", regwrite, 1); chk("memwb_memtoreg", memtoreg, 1);
    tick; chk("lw_back", state, S_FETCH);
    tick; tick; tick; chk("lw2_memrd", state, S_MEMRD);
    mem_ready = 1'b0; rst_n = 1'b0; #1;
    chk("midrst_state", state, 0); chk("midrst_memread", memread, 0); chk("midrst_iord", iord, 0);
    tick; tick;
    chk("midrst_hold_memread", memread, 0);
    rst_n = 1'b1; #1;
    chk("rel_state", state, S_FETCH); chk("rel_memread", memread, 1); chk("rel_irwrite", irwrite, 0);
    for (int i = 1; i <= 14; i++) begin
      chk("to_wait_err", mem_err, 0); chk("to_wait_irwrite", irwrite, 0);
      tick;
    end
    chk("to_err", mem_err, 1); chk("to_irwrite", irwrite, 0); chk("to_pcwrite", pcwrite, 0);
    tick; chk("to_state", state, S_FETCH); chk("to_err_clear", mem_err, 0);
    for (int i = 1; i <= 14; i++) tick;
    opcode = OP_SW; mem_ready = 1'b1; #1;
    chk("to_prio_err", mem_err, 0); chk("to_prio_irwrite", irwrite, 1);
    tick; chk("sw_decode", state, S_DECODE);
    tick; tick; chk("sw_memwr", state, S_MEMWR);
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold_state", state, S_MEMWR); chk("sw_memwrite", memwrite, 1); chk("sw_err", mem_err, 0);
      tick;
    end
    mem_ready = 1'b1; #1;
    chk("sw_last_memwrite", memwrite, 1); chk("sw_last_iord", iord, 1);
    tick; chk("sw_back", state, S_FETCH); opcode = OP_BLEZAL;
    tick; tick; chk("blezal_state", state, S_BLEZAL);
    chk("blezal_pcwc", pcwritecond, 1); chk("blezal_brcond", brcond, 1); chk("blezal_regdst", regdst, 2);
    chk("blezal_memtoreg", memtoreg, 2); chk("blezal_regwrite", regwrite, 1); chk("blezal_pcsource", pcsource, 1);
    tick; chk("blezal_back", state, S_FETCH); opcode = OP_JALPC;
    tick; tick; chk("jalpc_state", state, S_JALPC);
    chk("jalpc_pcwrite", pcwrite, 1); chk("jalpc_pcsource", pcsource, 2); chk("jalpc_regdst", regdst, 2);
    tick; opcode = 6'b111111;
    tick; chk("ill_decode", state, S_DECODE); chk("ill_pulse", illegal, 1);
    tick; chk("ill_back", state, S_FETCH); chk("ill_clear", illegal, 0);
    opcode = OP_R; funct = F_JMX;
    tick; chk("jmx_decode_ill", illegal, 0);
    tick; chk("jmx_rd", state, S_JMX_RD); chk("jmx_rd_iord", iord, 2); chk("jmx_rd_memread", memread, 1);
    tick; chk("jmx_jmp", state, S_JMX_JMP); chk("jmx_pcwrite", pcwrite, 1);
    chk("jmx_aluop", aluop, 3); chk("jmx_alusrca", alusrca, 2);
    tick; chk("jmx_back", state, S_FETCH); opcode = OP_BEQ;
    tick; tick; chk("beq_state", state, S_BEQ); chk("beq_aluop", aluop, 1);
    chk("beq_pcwc", pcwritecond, 1); chk("beq_pcsource", pcsource, 1); chk("beq_brcond", brcond, 0);
    tick; opcode = OP_R; funct = F_BRV;
    tick; tick; chk("brv_state", state, S_BRV); chk("brv_brcond", brcond, 2); chk("brv_pcsource", pcsource, 3);
    tick; opcode = OP_NANDI;
    tick; tick; chk("nandi_iex", state, S_IEX); chk("nandi_aluop", aluop, 3); chk("nandi_alusrcb", alusrcb, 2);
    tick; chk("nandi_iwb", state, S_IWB); chk("nandi_regwrite", regwrite, 1); chk("nandi_regdst", regdst, 0);
    tick; chk("nandi_back", state, S_FETCH);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
